tcdm_resp_router: RTL and testbench
===================================

Name: tcdm_resp_router

Overview:
- Sits directly downstream of the per-bank TCDM adapter.
- Consumes the adapter's response stream (bank metadata plus rdata) and steers each response to the initiator port selected by metadata field ini_addr.
- Initiator ports are the local cores followed by the remote groups.
- Each output has a small FIFO, so a stalled initiator blocks only its own traffic. Responses to one initiator keep their arrival order.

Parameters:
- NumInitiators, 8, number of output ports (NumCoresPerTile + NumGroups).
- IniAddrWidth, idx_width(NumInitiators), width of the routing field.
- MetaWidth, 20, width of the full bank metadata word, forwarded unchanged.
- DataWidth, 32, response data width.
- FifoDepth, 2, entries per output FIFO; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- in_valid_i  in  1  response valid from TCDM adapter.
- in_ready_o  out  1  router accepts the response.
- in_ini_addr_i  in  IniAddrWidth  target initiator (copy of meta.ini_addr).
- in_meta_i  in  MetaWidth  full bank metadata.
- in_rdata_i  in  DataWidth  response data.
- out_valid_o  out  NumInitiators  per-port valid.
- out_ready_i  in  NumInitiators  per-port ready.
- out_meta_o  out  NumInitiators*MetaWidth  per-port metadata; port k at bits [k*MetaWidth +: MetaWidth].
- out_rdata_o  out  NumInitiators*DataWidth  per-port data; same slicing.
- route_err_o  out  1  single-cycle pulse on an out-of-range ini_addr.
- occupancy_o  out  NumInitiators*idx_width(FifoDepth+1)  per-port fill level.

Behaviour:
- Reset (async assert, sync deassert):
  - All FIFOs empty, occupancy 0, pointers 0.
  - out_valid_o = 0, route_err_o = 0.
  - out_meta_o and out_rdata_o = 0.
  - in_ready_o = 1 after reset once the FIFOs are empty.
- Per-port FIFO:
  - Circular buffer with rd_ptr, wr_ptr and a count register 0..FifoDepth.
  - Pointers wrap from FifoDepth-1 to 0.
- in_ready_o = (in_ini_addr_i >= NumInitiators) OR (count[in_ini_addr_i] != FifoDepth).
  - Depends only on registered count, never on out_ready_i. This avoids a combinational ready path back to the adapter.
  - A full FIFO holds in_ready_o low even if that port is being popped the same cycle.
- Push: when in_valid_i && in_ready_o and the address is in range, write {in_meta_i, in_rdata_i} at wr_ptr of the target port and increment wr_ptr.
- Out-of-range address with in_valid_i = 1:
  - Response is accepted (in_ready_o = 1) and dropped.
  - route_err_o = 1 in the next cycle for exactly one cycle per dropped beat.
- Latency: a push at edge N makes out_valid_o[k] = 1 from edge N (visible in cycle N+1). Minimum latency is 1 cycle; there is no fall-through.
- Output: out_valid_o[k] = (count[k] != 0). out_meta_o and out_rdata_o slices show the entry at rd_ptr[k].
- Pop: on out_valid_o[k] && out_ready_i[k], increment rd_ptr[k].
- Simultaneous push and pop on the same port:
  - Count unchanged, both pointers advance.
  - Legal only when count < FifoDepth, because push requires not full.
  - With count = 1, the popped entry is the old head and the new entry becomes head next cycle.
- Push to one port and pop on other ports in the same cycle are independent.
- valid/data stability:
  - Once out_valid_o[k] is high, it stays high and its data stays stable until popped.
  - Upstream must hold in_* stable while in_valid_i && !in_ready_o. The router does not check this.
- occupancy_o[k] = count[k].
- Reset mid-operation discards all buffered responses immediately.

Test Plan:
- Single beat: reset, then in ini_addr=3, meta=0x0ABCD, rdata=0xDEADBEEF.
  - Expect out_valid_o=8'h08 one cycle later with matching slice 3.
  - out_ready_i[3]=1 → out_valid_o=0 next cycle, occupancy[3] 1→0.
- Backpressure/full (FifoDepth=2): out_ready_i=0, send 3 beats to port 5 with rdata 1,2,3.
  - in_ready_o goes 0 after the second beat; occupancy[5]=2.
  - Release ready → outputs 1,2,3 in order; in_ready_o returns 1 the cycle after the first pop.
- Isolation: port 2 full and stalled, then beats to ports 0 and 7.
  - Expect immediate acceptance and delivery on ports 0 and 7; port 2 data unchanged.
- Simultaneous push/pop: port 1 count=1, out_ready_i[1]=1 and a new beat to port 1 in the same cycle.
  - Expect count stays 1, old head delivered, new head visible next cycle.
  - Repeat 20 beats back-to-back at full throughput.
- Out of range (NumInitiators=6): beat with ini_addr=7.
  - Expect in_ready_o=1, one route_err_o pulse, no out_valid_o change.
- Mid-operation reset: 4 ports holding 2 entries each, assert rst_i asynchronously mid-cycle.
  - Expect out_valid_o=0 and occupancy all 0 immediately, without waiting for a clock edge.
  - Expect normal routing after deassert.

Source files
------------

// File: rtl/tcdm_resp_router.sv
// Response router: steers TCDM adapter responses to per-initiator output FIFOs
// selected by ini_addr, so one stalled initiator holds up only its own traffic.

module tcdm_resp_router_fifo #(
   parameter int unsigned Depth    = 2,
   parameter int unsigned Width    = 52,
   parameter int unsigned CntWidth = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [Width-1:0]    wdata,
   input  logic                pop_ready,
   output logic                valid,
   output logic [Width-1:0]    rdata,
   output logic [CntWidth-1:0] count,
   output logic                full
);
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Depth-1:0][Width-1:0] mem;
   logic [PtrWidth-1:0]         rd_ptr, wr_ptr;
   logic                        pop;

   function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid = (count != '0);
   assign full  = (count == CntWidth'(Depth));
   assign pop   = valid && pop_ready;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module tcdm_resp_router #(
   parameter int unsigned NumInitiators = 8,
   parameter int unsigned IniAddrWidth  = (NumInitiators > 1) ? $clog2(NumInitiators) : 1,
   parameter int unsigned MetaWidth     = 20,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned FifoDepth     = 2,
   localparam int unsigned CntWidth     = ((FifoDepth + 1) > 1) ? $clog2(FifoDepth + 1) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [IniAddrWidth-1:0]           in_ini_addr_i,
   input  logic [MetaWidth-1:0]              in_meta_i,
   input  logic [DataWidth-1:0]              in_rdata_i,
   output logic [NumInitiators-1:0]          out_valid_o,
   input  logic [NumInitiators-1:0]          out_ready_i,
   output logic [NumInitiators*MetaWidth-1:0] out_meta_o,
   output logic [NumInitiators*DataWidth-1:0] out_rdata_o,
   output logic                              route_err_o,
   output logic [NumInitiators*CntWidth-1:0] occupancy_o
);
   localparam int unsigned EntryWidth = MetaWidth + DataWidth;

   logic [NumInitiators-1:0]                 full, push;
   logic [NumInitiators-1:0][EntryWidth-1:0] head;
   logic                                     in_range, sel_full;

   // Ready looks only at the registered fill level, never at out_ready_i.
   always_comb begin
      in_range = 1'b0;
      sel_full = 1'b0;
      for (int k = 0; k < int'(NumInitiators); k++) begin
         if (in_ini_addr_i == IniAddrWidth'(k)) begin
            in_range = 1'b1;
            sel_full = full[k];
         end
      end
   end

   assign in_ready_o = !in_range || !sel_full;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) route_err_o <= 1'b0;
      else       route_err_o <= in_valid_i && !in_range;
   end

   for (genvar g = 0; g < int'(NumInitiators); g++) begin : g_port
      assign push[g] = in_valid_i && in_ready_o && (in_ini_addr_i == IniAddrWidth'(g));

      tcdm_resp_router_fifo #(
         .Depth    (FifoDepth),
         .Width    (EntryWidth),
         .CntWidth (CntWidth)
      ) i_fifo (
         .clk       (clk_i),
         .rst       (rst_i),
         .push      (push[g]),
         .wdata     ({in_meta_i, in_rdata_i}),
         .pop_ready (out_ready_i[g]),
         .valid     (out_valid_o[g]),
         .rdata     (head[g]),
         .count     (occupancy_o[g*CntWidth +: CntWidth]),
         .full      (full[g])
      );

      assign out_meta_o[g*MetaWidth +: MetaWidth]  = head[g][DataWidth +: MetaWidth];
      assign out_rdata_o[g*DataWidth +: DataWidth] = head[g][DataWidth-1:0];
   end
endmodule

// File: tb/tb_tcdm_resp_router.sv
// Bench for tcdm_resp_router: queue-per-port reference model, directed scenarios
// with literal expectations, then randomized traffic.

module tb_tcdm_resp_router;
   localparam int N  = 6;
   localparam int AW = 3;
   localparam int MW = 20;
   localparam int DW = 32;
   localparam int D  = 2;
   localparam int CW = 2;

   typedef logic [MW+DW-1:0] entry_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [AW-1:0]   in_addr = '0;
   logic [MW-1:0]   in_meta = '0;
   logic [DW-1:0]   in_rdata = '0;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready = '0;
   logic [N*MW-1:0] out_meta;
   logic [N*DW-1:0] out_rdata;
   logic            route_err;
   logic [N*CW-1:0] occupancy;

   tcdm_resp_router #(
      .NumInitiators (N),
      .IniAddrWidth  (AW),
      .MetaWidth     (MW),
      .DataWidth     (DW),
      .FifoDepth     (D)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_ini_addr_i (in_addr),
      .in_meta_i     (in_meta),
      .in_rdata_i    (in_rdata),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_meta_o    (out_meta),
      .out_rdata_o   (out_rdata),
      .route_err_o   (route_err),
      .occupancy_o   (occupancy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int     checks = 0;
   int     failures = 0;
   entry_t q[N][$];
   logic   exp_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      return (int'(in_addr) >= N) || (q[in_addr].size() < D);
   endfunction

   function automatic logic [DW-1:0] rd_slice(input int k);
      return out_rdata[k*DW +: DW];
   endfunction

   function automatic logic [MW-1:0] meta_slice(input int k);
      return out_meta[k*MW +: MW];
   endfunction

   function automatic logic [CW-1:0] occ_slice(input int k);
      return occupancy[k*CW +: CW];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) q[k].delete();
      exp_err = 1'b0;
   endtask

   // Model step: accept decision uses pre-edge fill, pops precede the push.
   task automatic model_edge();
      logic acc;
      acc = in_valid && model_ready();
      for (int k = 0; k < N; k++)
         if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
      if (acc && int'(in_addr) < N) q[in_addr].push_back({in_meta, in_rdata});
      exp_err = in_valid && (int'(in_addr) >= N);
   endtask

   task automatic compare();
      logic [N-1:0]    ev;
      logic [N*CW-1:0] eo;
      for (int k = 0; k < N; k++) begin
         ev[k] = (q[k].size() != 0);
         eo[k*CW +: CW] = CW'(q[k].size());
      end
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("occupancy", 64'(occupancy), 64'(eo));
      chk("route_err", 64'(route_err), 64'(exp_err));
      chk("in_ready", 64'(in_ready), 64'(model_ready()));
      for (int k = 0; k < N; k++)
         if (ev[k]) chk("head_data", 64'({meta_slice(k), rd_slice(k)}), 64'(q[k][0]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic drive(input logic v, input int a, input logic [MW-1:0] m, input logic [DW-1:0] d);
      in_valid = v;
      in_addr  = AW'(a);
      in_meta  = m;
      in_rdata = d;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_meta", 64'(out_meta), 64'd0);
      chk("rst_rdata", 64'(out_rdata), 64'd0);
      chk("rst_err", 64'(route_err), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);

      // Single beat to port 3
      drive(1, 3, 20'h0ABCD, 32'hDEADBEEF);
      cycle();
      drive(0, 0, 0, 0);
      chk("sb_valid", 64'(out_valid), 64'h08);
      chk("sb_meta", 64'(meta_slice(3)), 64'h0ABCD);
      chk("sb_rdata", 64'(rd_slice(3)), 64'hDEADBEEF);
      chk("sb_occ1", 64'(occ_slice(3)), 64'd1);
      out_ready = 6'b001000;
      cycle();
      chk("sb_popped", 64'(out_valid), 64'h00);
      chk("sb_occ0", 64'(occ_slice(3)), 64'd0);
      out_ready = '0;

      // Backpressure on port 5
      drive(1, 5, 20'h5, 32'd1);
      cycle();
      chk("bp_ready1", 64'(in_ready), 64'd1);
      drive(1, 5, 20'h5, 32'd2);
      cycle();
      chk("bp_ready_full", 64'(in_ready), 64'd0);
      chk("bp_occ2", 64'(occ_slice(5)), 64'd2);
      drive(1, 5, 20'h5, 32'd3);
      cycle();
      chk("bp_hold", 64'(in_ready), 64'd0);
      chk("bp_head1", 64'(rd_slice(5)), 64'd1);
      out_ready = 6'b100000;
      cycle();
      chk("bp_ready_back", 64'(in_ready), 64'd1);
      chk("bp_head2", 64'(rd_slice(5)), 64'd2);
      cycle();
      drive(0, 0, 0, 0);
      chk("bp_head3", 64'(rd_slice(5)), 64'd3);
      cycle();
      chk("bp_empty", 64'(out_valid[5]), 64'd0);
      out_ready = '0;

      // Isolation: port 2 full and stalled
      drive(1, 2, 20'h2, 32'hA1);
      cycle();
      drive(1, 2, 20'h2, 32'hA2);
      cycle();
      drive(1, 0, 20'h0, 32'hB0);
      #1;
      chk("iso_ready0", 64'(in_ready), 64'd1);
      cycle();
      chk("iso_p0", 64'(rd_slice(0)), 64'hB0);
      drive(1, 5, 20'h5, 32'hB5);
      cycle();
      drive(0, 0, 0, 0);
      chk("iso_valid", 64'(out_valid), 64'b100101);
      chk("iso_p5", 64'(rd_slice(5)), 64'hB5);
      chk("iso_p2_hold", 64'(rd_slice(2)), 64'hA1);
      out_ready = '1;
      repeat (3) cycle();
      chk("iso_drained", 64'(out_valid), 64'd0);
      out_ready = '0;

      // Simultaneous push/pop on port 1
      drive(1, 1, 20'h1, 32'h100);
      cycle();
      out_ready = 6'b000010;
      drive(1, 1, 20'h1, 32'h101);
      cycle();
      chk("pp_occ", 64'(occ_slice(1)), 64'd1);
      chk("pp_head", 64'(rd_slice(1)), 64'h101);
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 20'h1, DW'(32'h200 + i));
         cycle();
         chk("pp_stream", 64'({occ_slice(1), rd_slice(1)}), {30'd0, 2'd1, 32'h200 + 32'(i)});
      end
      drive(0, 0, 0, 0);
      cycle();
      out_ready = '0;

      // Out-of-range address
      drive(1, 7, 20'h7, 32'h77);
      #1;
      chk("oor_ready", 64'(in_ready), 64'd1);
      cycle();
      drive(0, 0, 0, 0);
      chk("oor_err", 64'(route_err), 64'd1);
      chk("oor_valid", 64'(out_valid), 64'd0);
      cycle();
      chk("oor_err_pulse", 64'(route_err), 64'd0);

      // Randomized traffic, honouring the upstream hold rule
      for (int i = 0; i < 1500; i++) begin
         if (!(in_valid && !model_ready()))
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  MW'($urandom), DW'($urandom));
         out_ready = N'($urandom) & N'($urandom);
         cycle();
      end
      drive(0, 0, 0, 0);
      out_ready = '1;
      repeat (3) cycle();
      out_ready = '0;

      // Mid-operation asynchronous reset
      for (int k = 0; k < 4; k++) begin
         drive(1, k, MW'(k), DW'(32'hC0 + k));
         cycle();
         drive(1, k, MW'(k), DW'(32'hD0 + k));
         cycle();
      end
      drive(0, 0, 0, 0);
      chk("mr_full", 64'(occupancy), 64'h0AA);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_occ", 64'(occupancy), 64'd0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      drive(1, 4, 20'h4, 32'hE4);
      cycle();
      drive(0, 0, 0, 0);
      chk("mr_after", 64'(out_valid), 64'h10);
      chk("mr_after_data", 64'(rd_slice(4)), 64'hE4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
